// File: rtl/spi_trace_pkg.sv
// Shared types and sizes for the SPI trace arbiter slice.
package spi_trace_pkg;

  localparam int NUM_SRC = 4;
  localparam int WORD_W  = 32;

  typedef enum logic [1:0] {
    SRC_PC,
    SRC_IMEM,
    SRC_DWR,
    SRC_DRD
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP
  } trace_state_e;

endpackage

// File: rtl/spi_trace_arbiter_if.sv
// Trace-tap strobes/words in, shared SPI probe pins out.
interface spi_trace_arbiter_if;
  import spi_trace_pkg::*;

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*WORD_W-1:0] src_data;
  logic                      spi_sck;
  logic                      spi_mosi;
  logic [NUM_SRC-1:0]        spi_cs;

  modport master (output src_valid, src_data, input spi_sck, spi_mosi, spi_cs);
  modport slave  (input src_valid, src_data, output spi_sck, spi_mosi, spi_cs);
endinterface

// File: rtl/spi_trace_shifter.sv
// One SPI mode-0 frame per load: SETUP half-period, 32 bits MSB-first, GAP half-period.
//
// state    | meaning
// ST_IDLE  | waiting for load, sck low, mosi low
// ST_SETUP | cs asserted, mosi = bit 31, sck low for CLK_DIV cycles
// ST_SHIFT | 32 bits, low phase then high phase of CLK_DIV cycles each
// ST_GAP   | cs released, sck/mosi low for CLK_DIV cycles
module spi_trace_shifter
  import spi_trace_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic              sck,
  output logic              mosi,
  output logic              cs_en,
  output logic              done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  trace_state_e      state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [4:0]        bit_cnt;
  logic              phase_hi;
  logic [WORD_W-1:0] shreg;
  logic              tc;

  assign tc = (div_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Divider, bit counter and shift register; mosi advances only on the high->low phase change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= DIV_LOAD;
      bit_cnt  <= 5'd31;
      phase_hi <= 1'b0;
      shreg    <= '0;
    end else if (state == ST_IDLE) begin
      div_cnt  <= DIV_LOAD;
      bit_cnt  <= 5'd31;
      phase_hi <= 1'b0;
      if (load) shreg <= word;
    end else if (tc) begin
      div_cnt <= DIV_LOAD;
      if (state == ST_SHIFT) begin
        if (!phase_hi) begin
          phase_hi <= 1'b1;
        end else begin
          phase_hi <= 1'b0;
          bit_cnt  <= bit_cnt - 5'd1;
          shreg    <= {shreg[WORD_W-2:0], 1'b0};
        end
      end
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load) state_nxt = ST_SETUP;
      ST_SETUP: if (tc) state_nxt = ST_SHIFT;
      ST_SHIFT: if (tc && phase_hi && bit_cnt == 5'd0) state_nxt = ST_GAP;
      ST_GAP:   if (tc) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sck   = (state == ST_SHIFT) && phase_hi;
    cs_en = (state == ST_SETUP) || (state == ST_SHIFT);
    mosi  = cs_en ? shreg[WORD_W-1] : 1'b0;
    done  = (state == ST_GAP) && tc;
  end

endmodule

// File: rtl/spi_trace_arbiter.sv
// Four trace sources share one SPI probe port via one-word buffers and a round-robin grant.
// Build option TRACE_DROP_CNT_EN adds saturating per-source drop counters on drop_cnt.
module spi_trace_arbiter
  import spi_trace_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_trace_arbiter_if.slave   tif,
  output logic                 busy,
  output logic [NUM_SRC*8-1:0] drop_cnt
);

  logic [WORD_W-1:0]  buf_q [NUM_SRC];
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] grant_oh;
  logic [1:0]         last_grant;
  logic [1:0]         cur_src;
  logic [1:0]         grant_idx;
  logic               grant_vld;
  logic               frame_active;
  logic               cs_en;
  logic               done;

  // Search starts one past the previous grant so every full buffer is served within four frames.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!frame_active && !grant_vld && full[last_grant + 2'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = last_grant + 2'(k);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) grant_oh[i] = grant_vld && (grant_idx == 2'(i));
  end

  // A strobe landing on the grant cycle refills the buffer rather than being dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      for (int i = 0; i < NUM_SRC; i++) buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (tif.src_valid[i] && (!full[i] || grant_oh[i])) begin
          buf_q[i] <= tif.src_data[WORD_W*i +: WORD_W];
          full[i]  <= 1'b1;
        end else if (grant_oh[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_active <= 1'b0;
      last_grant   <= 2'(SRC_DRD);
      cur_src      <= 2'(SRC_PC);
    end else if (grant_vld) begin
      frame_active <= 1'b1;
      last_grant   <= grant_idx;
      cur_src      <= grant_idx;
    end else if (done) begin
      frame_active <= 1'b0;
    end
  end

  assign busy = frame_active;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) tif.spi_cs[i] = !(cs_en && (cur_src == 2'(i)));
  end

  spi_trace_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (grant_vld),
    .word  (buf_q[grant_idx]),
    .sck   (tif.spi_sck),
    .mosi  (tif.spi_mosi),
    .cs_en (cs_en),
    .done  (done)
  );

`ifdef TRACE_DROP_CNT_EN
  logic [NUM_SRC-1:0] drop_ev;
  logic [7:0]         drop_q [NUM_SRC];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) drop_ev[i] = tif.src_valid[i] && full[i] && !grant_oh[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) drop_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (drop_ev[i] && drop_q[i] != 8'hFF) drop_q[i] <= drop_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) drop_cnt[8*i +: 8] = drop_q[i];
  end
`else
  assign drop_cnt = '0;
`endif

endmodule
